// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, response FIFO, redirect flush
//
// Purpose:
//   Holds the fetch PC and issues in-order word requests to instruction memory.
//   Returned words are buffered in a FIFO_DEPTH-entry FIFO and handed to decode
//   with a valid/ready handshake. A redirect flushes the FIFO and drops every
//   response still in flight.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   imem_req_valid/addr/ready       fetch request channel (word-aligned address)
//   imem_rsp_valid/data             in-order response channel, no backpressure
//   redirect, redirect_pc           branch/jump taken, refetch from redirect_pc
//   instr_valid/instr/instr_pc      FIFO head to decode (NOP when empty)
//   instr_ready                     decode consumes the head
//   op, funct3, funct7b5            field slices of instr for the controller
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_stall_cnt  saturating count of cycles decode wanted a word but had none
//   redirect_cnt     saturating count of redirect cycles

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_stall_cnt,
  output logic [15:0] redirect_cnt,
`endif
  output logic        funct7b5
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_word [FIFO_DEPTH];
  logic [31:0]   r_pc   [FIFO_DEPTH];

  logic          w_credit;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;
  logic          w_unused;

  // Buffered plus in-flight words never exceed the FIFO size, so every
  // response always has a slot waiting for it.
  assign w_credit       = (32'(r_count) + 32'(r_outst)) < FIFO_DEPTH;
  assign imem_req_valid = !reset && !redirect && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response landing in the redirect cycle belongs to the old stream.
  assign w_push = imem_rsp_valid && (r_drop == '0) && !redirect;

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid && instr_ready && !redirect;
  assign instr       = instr_valid ? r_word[r_rd_ptr] : NOP;
  // When empty, report the PC the next buffered word will carry.
  assign instr_pc    = instr_valid ? r_pc[r_rd_ptr] : r_resp_pc;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      // Every response retires one outstanding request, dropped or not.
      r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        // Everything still in flight after this edge is stale.
        r_drop     <= r_outst - CW'(imem_rsp_valid);
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (imem_rsp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_word[r_wr_ptr] <= imem_rsp_data;
      r_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      assert (32'(r_count) < FIFO_DEPTH);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_redir_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (instr_ready && !instr_valid && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (redirect && (r_redir_cnt != '1)) begin
        r_redir_cnt <= r_redir_cnt + 16'd1;
      end
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
  assign redirect_cnt    = r_redir_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset          = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect       = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        instr_ready    = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt;
  logic [15:0] redirect_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .op             (op),
    .funct3         (funct3),
`ifdef FETCH_PERF_CNT_EN
    .fetch_stall_cnt(fetch_stall_cnt),
    .redirect_cnt   (redirect_cnt),
`endif
    .funct7b5       (funct7b5)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          mem_lat = 1;
  bit          rand_lat = 0;
  logic [31:0] m_fetch_pc = RST_PC;
  bit          last_fire;
  logic [31:0] last_fire_addr;
  bit          last_pop;
  logic [31:0] last_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // One clock: scoreboard checks before the edge, memory and reference model after it.
  task automatic cycle();
    bit rst, redir, rsp, fire;
    logic [31:0] faddr, rpc;
    req_t r;
    exp_t e;
    int lat;
    #1;
    rst = reset; redir = redirect; rpc = redirect_pc; rsp = imem_rsp_valid;
    fire = imem_req_valid && imem_req_ready; faddr = imem_req_addr;
    last_pop = 0;
    if (!rst) begin
      n_run++;
      if (imem_req_valid !== (!redir && (exp_q.size() + pend.size() < DEPTH))) begin
        n_fail++; $display("FAIL req_valid: got %b, in_fifo %0d in_flight %0d redirect %b", imem_req_valid, exp_q.size(), pend.size(), redir);
      end
      n_run++;
      if (instr_valid !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL instr_valid: got %b, expected %b", instr_valid, exp_q.size() != 0);
      end
      if (fire) begin
        n_run++;
        if (faddr !== m_fetch_pc) begin
          n_fail++; $display("FAIL req_addr: got %h, expected %h", faddr, m_fetch_pc);
        end
      end
      if (instr_valid && instr_ready && !redir && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_pop = 1; last_pop_pc = instr_pc;
        n_run++;
        if (instr !== e.word || instr_pc !== e.pc) begin
          n_fail++; $display("FAIL head: got %h@%h, expected %h@%h", instr, instr_pc, e.word, e.pc);
        end
        n_run++;
        if (op !== e.word[6:0] || funct3 !== e.word[14:12] || funct7b5 !== e.word[30]) begin
          n_fail++; $display("FAIL fields: got %h/%h/%b, expected %h/%h/%b", op, funct3, funct7b5, e.word[6:0], e.word[14:12], e.word[30]);
        end
      end
    end
    last_fire = fire; last_fire_addr = faddr;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pend.delete(); exp_q.delete(); m_fetch_pc = RST_PC; epoch++;
    end else begin
      if (rsp && pend.size() != 0) begin
        r = pend.pop_front();
        if (!redir && r.epoch == epoch) exp_q.push_back('{pc: r.addr, word: mem_word(r.addr)});
      end
      if (redir) begin
        exp_q.delete(); epoch++; m_fetch_pc = {rpc[31:2], 2'b00};
      end
      if (fire) begin
        lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
        pend.push_back('{addr: faddr, epoch: epoch, due: cyc + lat - 1});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;
    end
  endtask

  task automatic apply_reset();
    redirect = 0; reset = 1; cycle(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; instr_ready = 1; imem_req_ready = 1;
    cycle(); cycle();
    n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", instr_valid); end
    n_run++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h, expected %h", instr, NOP); end
    n_run++; if (instr_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h, expected %h", instr_pc, RST_PC); end
    n_run++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", imem_req_valid); end
    n_run++; if (op !== 7'h13 || funct3 !== 3'h0 || funct7b5 !== 1'b0) begin n_fail++; $display("FAIL reset_fields: got %h/%h/%b, expected 13/0/0", op, funct3, funct7b5); end
    reset = 0;
  endtask

  task automatic test_stream();
    int fc[$];
    logic [31:0] fa[$];
    instr_ready = 1; imem_req_ready = 1; mem_lat = 1; rand_lat = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_fire) begin fc.push_back(i); fa.push_back(last_fire_addr); end
    end
    n_run++;
    if (fa.size() < 3) begin
      n_fail++; $display("FAIL stream_count: got %0d requests, expected at least 3", fa.size());
    end else begin
      if (fa[0] !== 32'h100 || fa[1] !== 32'h104 || fa[2] !== 32'h108) begin
        n_fail++; $display("FAIL stream_addr: got %h %h %h, expected 100 104 108", fa[0], fa[1], fa[2]);
      end
      n_run++;
      // Depth 2: the third request waits one cycle for the first word to leave.
      if (fc[0] != 0 || fc[1] != 1 || fc[2] != 3) begin
        n_fail++; $display("FAIL stream_timing: got cycles %0d %0d %0d, expected 0 1 3", fc[0], fc[1], fc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] pcs[$];
    instr_ready = 0; imem_req_ready = 1; mem_lat = 1;
    apply_reset();
    n = 0;
    repeat (10) begin cycle(); if (last_fire) n++; end
    n_run++; if (n != DEPTH) begin n_fail++; $display("FAIL bp_requests: got %0d, expected %0d", n, DEPTH); end
    n_run++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b, expected 0", imem_req_valid); end
    instr_ready = 1;
    for (int i = 0; i < 20 && pcs.size() < 4; i++) begin
      cycle(); if (last_pop) pcs.push_back(last_pop_pc);
    end
    n_run++;
    if (pcs.size() < 4) begin
      n_fail++; $display("FAIL bp_drain: got %0d words, expected 4", pcs.size());
    end else if (pcs[0] !== 32'h100 || pcs[1] !== 32'h104 || pcs[2] !== 32'h108 || pcs[3] !== 32'h10C) begin
      n_fail++; $display("FAIL bp_order: got %h %h %h %h, expected 100 104 108 10c", pcs[0], pcs[1], pcs[2], pcs[3]);
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] pcs[$];
    bit stale;
    instr_ready = 1; imem_req_ready = 1; mem_lat = 3;
    apply_reset();
    for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
    n_run++; if (pend.size() != 2) begin n_fail++; $display("FAIL rd_setup: got %0d in flight, expected 2", pend.size()); end
    redirect = 1; redirect_pc = 32'h200; cycle(); redirect = 0;
    stale = 0;
    for (int i = 0; i < 40 && pcs.size() < 3; i++) begin
      cycle();
      if (last_pop) begin pcs.push_back(last_pop_pc); if (last_pop_pc < 32'h200) stale = 1; end
    end
    n_run++;
    if (pcs.size() < 3) begin
      n_fail++; $display("FAIL rd_words: got %0d words, expected 3", pcs.size());
    end else if (pcs[0] !== 32'h200) begin
      n_fail++; $display("FAIL rd_first_pc: got %h, expected 200", pcs[0]);
    end
    n_run++; if (stale) begin n_fail++; $display("FAIL rd_stale: got a 0x10x word at decode, expected none"); end
    mem_lat = 1;
  endtask

  task automatic test_redirect_collide();
    bit hit;
    instr_ready = 1; imem_req_ready = 1; mem_lat = 1;
    apply_reset();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (instr_valid && imem_rsp_valid) hit = 1; else cycle();
    end
    n_run++; if (!hit) begin n_fail++; $display("FAIL rc_setup: got no cycle with head and response, expected one"); end
    redirect = 1; redirect_pc = 32'h203; cycle(); redirect = 0;
    n_run++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL rc_flush: got %b/%h, expected 0/%h", instr_valid, instr, NOP); end
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cycle(); hit = last_fire; end
    n_run++;
    if (!hit || last_fire_addr !== 32'h200) begin n_fail++; $display("FAIL rc_addr: got %h (fired %b), expected 200", last_fire_addr, hit); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    instr_ready = 0; imem_req_ready = 1; mem_lat = 1;
    apply_reset();
    for (int i = 0; i < 20 && exp_q.size() < DEPTH; i++) cycle();
    n_run++; if (exp_q.size() != DEPTH) begin n_fail++; $display("FAIL rm_setup: got %0d buffered, expected %0d", exp_q.size(), DEPTH); end
    reset = 1; cycle();
    n_run++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL rm_flush: got %b/%h, expected 0/%h", instr_valid, instr, NOP); end
    n_run++; if (instr_pc !== RST_PC) begin n_fail++; $display("FAIL rm_pc: got %h, expected %h", instr_pc, RST_PC); end
    reset = 0; instr_ready = 1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cycle(); hit = last_fire; end
    n_run++;
    if (!hit || last_fire_addr !== RST_PC) begin n_fail++; $display("FAIL rm_addr: got %h (fired %b), expected %h", last_fire_addr, hit, RST_PC); end
  endtask

  task automatic test_back_to_back();
    int pops;
    rand_lat = 1;
    apply_reset();
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect       = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 3))) : $urandom;
      cycle();
      if (last_pop) pops++;
    end
    redirect = 0; imem_req_ready = 0; instr_ready = 1;
    for (int i = 0; i < 50 && (pend.size() != 0 || exp_q.size() != 0); i++) cycle();
    n_run++; if (pend.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d/%0d left, expected 0/0", pend.size(), exp_q.size()); end
    n_run++; if (pops == 0) begin n_fail++; $display("FAIL b2b_pops: got 0 words, expected some"); end
    rand_lat = 0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    imem_req_ready = 0; instr_ready = 1;
    apply_reset();
    repeat (10) cycle();
    n_run++; if (fetch_stall_cnt !== 32'd10) begin n_fail++; $display("FAIL perf_stall: got %0d, expected 10", fetch_stall_cnt); end
    redirect = 1; redirect_pc = 32'h300; cycle(); redirect = 0;
    n_run++; if (redirect_cnt !== 16'd1) begin n_fail++; $display("FAIL perf_redirect: got %0d, expected 1", redirect_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_reset_mid();
    test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

endmodule
